// File: rtl/sim_target_sched.sv
// Scan-synchronous configuration scheduler for the four-target radar simulator.
// Host writes land in shadow registers; active registers load only at a scan boundary or on immediate request.
`timescale 1ns/1ps
module sim_target_sched #(
  parameter int LT_W       = 8,
  parameter int SCAN_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [31:0]           wr_data,
  output logic                  wr_ready,
  input  logic [11:0]           bear,
  output logic [31:0]           angle,
  output logic [31:0]           angle2,
  output logic [31:0]           angle3,
  output logic [31:0]           angle4,
  output logic [9:0]            range,
  output logic [9:0]            range2,
  output logic [9:0]            range3,
  output logic [9:0]            range4,
  output logic [31:0]           angle_mode,
  output logic [31:0]           range_mode,
  output logic [3:0]            target_enable,
  output logic                  pending,
  output logic                  scan_tick,
  output logic                  commit_done,
  output logic [SCAN_CNT_W-1:0] scan_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, COMMIT = 1'b1} state_e;

  localparam logic [31:0]     ANGLE_MASK = 32'h0FFF_0FFF;
  localparam logic [31:0]     MODE_MASK  = 32'h0707_0707;
  localparam logic [LT_W-1:0] LT_ONE     = {{(LT_W-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic                    s1_q, s2_q, s3_q;
  logic                    scan_tick_q, scan_tick_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    pending_q, pending_d;
  logic                    commit_done_q, commit_done_d;
  logic [SCAN_CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [31:0]             sh_angle_q [4];
  logic [31:0]             sh_angle_d [4];
  logic [9:0]              sh_range_q [4];
  logic [9:0]              sh_range_d [4];
  logic [LT_W-1:0]         sh_lt_q [4];
  logic [LT_W-1:0]         sh_lt_d [4];
  logic [31:0]             sh_amode_q, sh_amode_d, sh_rmode_q, sh_rmode_d;
  logic [3:0]              sh_en_q, sh_en_d;
  logic [31:0]             act_angle_q [4];
  logic [31:0]             act_angle_d [4];
  logic [9:0]              act_range_q [4];
  logic [9:0]              act_range_d [4];
  logic [LT_W-1:0]         lt_q [4];
  logic [LT_W-1:0]         lt_d [4];
  logic [31:0]             act_amode_q, act_amode_d, act_rmode_q, act_rmode_d;
  logic [3:0]              act_en_q, act_en_d;
  logic                    tick_s, wr_fire_s, ctrl_wr_s, go_commit_s;
  logic                    unused_bear_s;

  assign unused_bear_s = ^bear[10:0];

  // Next-state logic: shadow writes, boundary detection, aging, commit.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    sh_amode_d    = sh_amode_q;
    sh_rmode_d    = sh_rmode_q;
    sh_en_d       = sh_en_q;
    act_amode_d   = act_amode_q;
    act_rmode_d   = act_rmode_q;
    act_en_d      = act_en_q;
    for (int i = 0; i < 4; i++) begin
      sh_angle_d[i]  = sh_angle_q[i];
      sh_range_d[i]  = sh_range_q[i];
      sh_lt_d[i]     = sh_lt_q[i];
      act_angle_d[i] = act_angle_q[i];
      act_range_d[i] = act_range_q[i];
      lt_d[i]        = lt_q[i];
    end

    tick_s      = s3_q & ~s2_q;
    scan_tick_d = tick_s;
    scan_cnt_d  = scan_cnt_q + {{(SCAN_CNT_W-1){1'b0}}, tick_s};
    wr_fire_s   = wr_en & wr_ready_q;
    ctrl_wr_s   = wr_fire_s && (wr_addr == 4'd11);

    if (wr_fire_s) begin
      case (wr_addr)
        4'd0, 4'd1, 4'd2, 4'd3: sh_angle_d[wr_addr[1:0]] = wr_data & ANGLE_MASK;
        4'd4, 4'd5, 4'd6, 4'd7: sh_range_d[wr_addr[1:0]] = wr_data[9:0];
        4'd8:  sh_amode_d = wr_data & MODE_MASK;
        4'd9:  sh_rmode_d = wr_data & MODE_MASK;
        4'd10: sh_en_d    = wr_data[3:0];
        4'd12: begin
          for (int i = 0; i < 4; i++) sh_lt_d[i] = wr_data[8*i +: LT_W];
        end
        default: begin
        end
      endcase
    end else begin
      sh_en_d = sh_en_q;
    end

    if (ctrl_wr_s && wr_data[0]) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    // A counter reaching zero on a scan boundary retires its target; zero itself means forever.
    if (scan_tick_q) begin
      for (int i = 0; i < 4; i++) begin
        if ((lt_q[i] != '0) && act_en_q[i]) begin
          lt_d[i] = lt_q[i] - LT_ONE;
          if (lt_q[i] == LT_ONE) act_en_d[i] = 1'b0;
        end
      end
    end else begin
      act_en_d = act_en_q;
    end

    go_commit_s = (scan_tick_q && (pending_q || (ctrl_wr_s && wr_data[0]))) ||
                  (ctrl_wr_s && wr_data[1]);

    case (state_q)
      IDLE: begin
        if (go_commit_s) state_d = COMMIT;
        else             state_d = IDLE;
      end
      COMMIT: begin
        state_d     = IDLE;
        pending_d   = 1'b0;
        act_amode_d = sh_amode_q;
        act_rmode_d = sh_rmode_q;
        act_en_d    = sh_en_q;
        for (int i = 0; i < 4; i++) begin
          act_angle_d[i] = sh_angle_q[i];
          act_range_d[i] = sh_range_q[i];
          lt_d[i]        = sh_lt_q[i];
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ready_d    = (state_d == IDLE);
    commit_done_d = (state_q == COMMIT);
  end

  // State and register update with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      scan_tick_q   <= 1'b0;
      wr_ready_q    <= 1'b1;
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      scan_cnt_q    <= '0;
      sh_amode_q    <= 32'h0;
      sh_rmode_q    <= 32'h0;
      sh_en_q       <= 4'h0;
      act_amode_q   <= 32'h0;
      act_rmode_q   <= 32'h0;
      act_en_q      <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        sh_angle_q[i]  <= 32'h0;
        sh_range_q[i]  <= 10'h0;
        sh_lt_q[i]     <= '0;
        act_angle_q[i] <= 32'h0;
        act_range_q[i] <= 10'h0;
        lt_q[i]        <= '0;
      end
    end else begin
      state_q       <= state_d;
      s1_q          <= bear[11];
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      scan_tick_q   <= scan_tick_d;
      wr_ready_q    <= wr_ready_d;
      pending_q     <= pending_d;
      commit_done_q <= commit_done_d;
      scan_cnt_q    <= scan_cnt_d;
      sh_amode_q    <= sh_amode_d;
      sh_rmode_q    <= sh_rmode_d;
      sh_en_q       <= sh_en_d;
      act_amode_q   <= act_amode_d;
      act_rmode_q   <= act_rmode_d;
      act_en_q      <= act_en_d;
      for (int i = 0; i < 4; i++) begin
        sh_angle_q[i]  <= sh_angle_d[i];
        sh_range_q[i]  <= sh_range_d[i];
        sh_lt_q[i]     <= sh_lt_d[i];
        act_angle_q[i] <= act_angle_d[i];
        act_range_q[i] <= act_range_d[i];
        lt_q[i]        <= lt_d[i];
      end
    end
  end

  assign wr_ready      = wr_ready_q;
  assign angle         = act_angle_q[0];
  assign angle2        = act_angle_q[1];
  assign angle3        = act_angle_q[2];
  assign angle4        = act_angle_q[3];
  assign range         = act_range_q[0];
  assign range2        = act_range_q[1];
  assign range3        = act_range_q[2];
  assign range4        = act_range_q[3];
  assign angle_mode    = act_amode_q;
  assign range_mode    = act_rmode_q;
  assign target_enable = act_en_q;
  assign pending       = pending_q;
  assign scan_tick     = scan_tick_q;
  assign commit_done   = commit_done_q;
  assign scan_cnt      = scan_cnt_q;

endmodule
